vga_timing_gen: RTL

- Parametrised VGA raster timing generator for the rj32 front-panel/video path, clocked in the pixel clock domain (e.g. the 25 MHz PLL output).
- Replaces per-resolution timing constants selected by `ifdef` with module parameters, so 640x480, 720x400 and 720x480 all come from one block.
- Provides pixel coordinates for tile/map BRAM addressing.
- Provides hs/vs/de delayed by a configurable pipeline depth to line up with BRAM read latency.
- Adds a pixel clock-enable and line/frame strobes.

---
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with delayed syncs and strobes
// Define VGA_FRAME_COUNTER_EN to build the frame_count register; otherwise frame_count is tied to 0.
module vga_timing_gen #(
  parameter int H_RES      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int H_NEG      = 1,
  parameter int V_RES      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int V_NEG      = 1,
  parameter int CNT_W      = 12,
  parameter int PIPE_DELAY = 2,
  parameter int FRAME_W    = 16
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic               ce,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               active,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_RES);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_RES);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_RES + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_RES + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_RES + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_RES + V_FP + V_SYNC);
  localparam logic             H_POL      = (H_NEG != 0);
  localparam logic             V_POL      = (V_NEG != 0);

  generate
    if ((longint'(H_TOTAL) > (longint'(1) << CNT_W)) ||
        (longint'(V_TOTAL) > (longint'(1) << CNT_W))) begin : g_cnt_w_check
      $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_pipe_check
      $error("vga_timing_gen: PIPE_DELAY must be 0..8");
    end
  endgenerate

  logic x_wrap;
  logic y_wrap;
  logic hs_raw;
  logic vs_raw;
  logic hs_d;
  logic vs_d;
  logic de_d;

  assign x_wrap = (x == H_LAST);
  assign y_wrap = (y == V_LAST);
  assign active = (x < H_ACT) && (y < V_ACT);
  assign hs_raw = (x >= H_SYNC_BEG) && (x < H_SYNC_END);
  assign vs_raw = (y >= V_SYNC_BEG) && (y < V_SYNC_END);

  // Strobes are cleared on every clock and only set by an enabled wrap edge.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= ce && x_wrap;
      frame_start <= ce && x_wrap && y_wrap;
      if (ce) begin
        x <= x_wrap ? '0 : x + CNT_W'(1);
        if (x_wrap) begin
          y <= y_wrap ? '0 : y + CNT_W'(1);
        end
      end
    end
  end

  // Stages hold raw active-high values so a cleared stage reads as inactive after polarity.
  generate
    if (PIPE_DELAY == 0) begin : g_no_pipe
      assign hs_d = hs_raw;
      assign vs_d = vs_raw;
      assign de_d = active;
    end else begin : g_pipe
      logic [PIPE_DELAY-1:0] hs_pipe;
      logic [PIPE_DELAY-1:0] vs_pipe;
      logic [PIPE_DELAY-1:0] de_pipe;

      always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
          hs_pipe <= '0;
          vs_pipe <= '0;
          de_pipe <= '0;
        end else if (ce) begin
          hs_pipe[0] <= hs_raw;
          vs_pipe[0] <= vs_raw;
          de_pipe[0] <= active;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
            de_pipe[i] <= de_pipe[i-1];
          end
        end
      end

      assign hs_d = hs_pipe[PIPE_DELAY-1];
      assign vs_d = vs_pipe[PIPE_DELAY-1];
      assign de_d = de_pipe[PIPE_DELAY-1];
    end
  endgenerate

  assign hs = hs_d ^ H_POL;
  assign vs = vs_d ^ V_POL;
  assign de = de_d;

`ifdef VGA_FRAME_COUNTER_EN
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      frame_count <= '0;
    end else if (ce && x_wrap && y_wrap) begin
      frame_count <= frame_count + FRAME_W'(1);
    end
  end
`else
  assign frame_count = '0;
`endif

endmodule
